pmem_responder: RTL and testbench

Memory-side responder for the RV32E core's load/store traffic: a single-port, word-organised RAM with a valid/ready request channel and a valid/ready response channel. It accepts one request at a time and applies byte-lane writes from a byte-count size encoding (1/2/4). It returns the full aligned word on reads; the core does the offset shift and extension. It sits between the core's memory interface and simulation/FPGA RAM, with a programmable access latency to model slow memory.

---
 rtl/pmem_pkg.sv | 19 +
 rtl/pmem_lane_ctrl.sv | 35 +++
 rtl/pmem_responder.sv | 136 +++++++++++++
 tb/tb_pmem_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_pkg.sv
// Shared types and constants for the word-organised load/store responder.
package pmem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

endpackage

// File: rtl/pmem_lane_ctrl.sv
// Maps a byte-count size and byte offset onto write lanes, shifted write data
// and the illegal-size / word-crossing flags.
module pmem_lane_ctrl
  import pmem_pkg::*;
(
  input  logic [2:0]        i_size,
  input  logic [1:0]        i_offset,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [BE_W-1:0]   o_be_c,
  output logic [DATA_W-1:0] o_wdata_c,
  output logic              o_size_bad_c,
  output logic              o_misalign_c
);

  logic [BE_W-1:0] w_be_base;
  logic [3:0]      w_end;

  always_comb begin
    w_be_base    = '0;
    o_size_bad_c = 1'b0;
    case (i_size)
      SZ_B:    w_be_base = 4'b0001;
      SZ_H:    w_be_base = 4'b0011;
      SZ_W:    w_be_base = 4'b1111;
      default: o_size_bad_c = 1'b1;
    endcase
  end

  // Last byte position plus one; anything past 4 spills into the next word.
  assign w_end        = 4'(i_offset) + 4'(i_size);
  assign o_misalign_c = !o_size_bad_c && (w_end > 4'd4);
  assign o_be_c       = w_be_base << i_offset;
  assign o_wdata_c    = i_wdata << {i_offset, 3'b000};

endmodule

// File: rtl/pmem_responder.sv
// Single-port word RAM answering one load/store at a time over valid/ready
// request and response channels, with a programmable response latency.
module pmem_responder
  import pmem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned       DEPTH_WORDS = 4096,
  parameter int unsigned       LATENCY     = 1,
  parameter string             INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_size,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned       IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam bit                NO_WAIT  = (LATENCY <= 1);

  pmem_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rdata, w_rdata_nxt;
  logic              r_rsp_err, w_err_nxt;
  logic              w_mem_we;

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_in_range;
  logic              w_accept;
  logic              w_err;
  logic [DATA_W-1:0] w_rd_word;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_wdata_sh;
  logic              w_size_bad;
  logic              w_misalign;

  // Unsigned subtraction wraps addresses below the base far out of range.
  assign w_off      = req_addr - BASE_ADDR;
  assign w_in_range = (w_off < SPAN);
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_accept   = req_valid && (r_state == IDLE);
  assign w_err      = !w_in_range || w_size_bad || w_misalign;
  assign w_rd_word  = r_mem[w_idx];

  pmem_lane_ctrl u_lane (
    .i_size       (req_size),
    .i_offset     (req_addr[1:0]),
    .i_wdata      (req_wdata),
    .o_be_c       (w_be),
    .o_wdata_c    (w_wdata_sh),
    .o_size_bad_c (w_size_bad),
    .o_misalign_c (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rdata_nxt;
      r_rsp_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = NO_WAIT ? RESP : WAIT;
      WAIT:    if (r_cnt <= CNT_W'(1)) w_state_nxt = RESP;
      RESP:    if (r_rsp_valid && rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Response payload is captured once on accept and held until the handshake.
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rdata_nxt     = r_rsp_rdata;
    w_err_nxt       = r_rsp_err;
    w_mem_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_nxt       = CNT_LOAD;
          w_rsp_valid_nxt = NO_WAIT;
          w_err_nxt       = w_err;
          w_rdata_nxt     = (req_we || w_err) ? '0 : w_rd_word;
          w_mem_we        = req_we && !w_err;
        end
      end
      WAIT: begin
        if (r_cnt <= CNT_W'(1)) w_rsp_valid_nxt = 1'b1;
        w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
      end
      RESP: begin
        if (r_rsp_valid && rsp_ready) w_rsp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Contents survive reset; only the write strobe is suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_pmem_responder.sv
// Bench for pmem_responder: three instances (latency 1, 3, 4) share one request
// bus and are checked against a byte-level memory model.
module tb_pmem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          NI    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] req_valid;
  logic [NI-1:0] req_ready;
  logic [NI-1:0] rsp_valid;
  logic [NI-1:0] rsp_err;
  logic [31:0]   rsp_rdata [NI];
  logic          req_we;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic [2:0]    req_size;
  logic          rsp_ready;

  int unsigned n_vec = 0;
  int unsigned n_mis = 0;

  logic [31:0] model_mem [NI][DEPTH];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pmem_responder #(
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_size  (req_size),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  function automatic int exp_lat(input int sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 3 : 4);
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic [2:0] sz);
    if (longint'(a) < longint'(BASE) || longint'(a) >= longint'(BASE) + 4 * DEPTH) return 1'b1;
    if (!(sz == 3'd1 || sz == 3'd2 || sz == 3'd4)) return 1'b1;
    if (int'(a[1:0]) + int'(sz) > 4) return 1'b1;
    return 1'b0;
  endfunction

  // Byte-by-byte model: writes place wdata byte k at offset+k; reads return the word.
  function automatic void model_apply(input int sel, input bit we, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [2:0] sz,
                                      output logic [31:0] exp_rd, output bit exp_err);
    int idx;
    int pos;
    logic [31:0] w;
    exp_err = model_err(a, sz);
    exp_rd  = 32'h0;
    if (exp_err) return;
    idx = int'((a - BASE) >> 2);
    if (we) begin
      w = model_mem[sel][idx];
      for (int k = 0; k < int'(sz); k++) begin
        pos = int'(a[1:0]) + k;
        w[8*pos +: 8] = wd[8*k +: 8];
      end
      model_mem[sel][idx] = w;
    end else begin
      exp_rd = model_mem[sel][idx];
    end
  endfunction

  task automatic do_txn(input int sel, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] sz, input int hold, input string tag,
                        output logic [31:0] got_rd, output logic got_err);
    logic [31:0] exp_rd;
    bit          exp_err;
    int          lat;
    int          wt;
    got_rd  = 'x;
    got_err = 1'bx;
    wt = 0;
    while (req_ready[sel] !== 1'b1 && wt < 50) begin
      @(posedge clk); #1; wt++;
    end
    n_vec++;
    if (req_ready[sel] !== 1'b1) begin
      n_mis++;
      $display("FAIL %s ready_wait: req_ready=%b, required 1", tag, req_ready[sel]);
      return;
    end
    req_valid[sel] = 1'b1;
    req_we = we; req_addr = a; req_wdata = wd; req_size = sz;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_size = 3'($urandom);
    model_apply(sel, we, a, wd, sz, exp_rd, exp_err);
    lat = 1;
    while (rsp_valid[sel] !== 1'b1 && lat < 40) begin
      n_vec++;
      if (req_ready[sel] !== 1'b0) begin
        n_mis++;
        $display("FAIL %s busy_ready: req_ready=%b in wait cycle %0d, required 0", tag, req_ready[sel], lat);
      end
      @(posedge clk); #1; lat++;
    end
    n_vec++;
    if (lat != exp_lat(sel)) begin
      n_mis++;
      $display("FAIL %s latency: rsp_valid after %0d cycles, required %0d", tag, lat, exp_lat(sel));
      if (rsp_valid[sel] !== 1'b1) return;
    end
    got_rd  = rsp_rdata[sel];
    got_err = rsp_err[sel];
    n_vec++;
    if (got_rd !== exp_rd || got_err !== exp_err || req_ready[sel] !== 1'b0) begin
      n_mis++;
      $display("FAIL %s response: rdata=%h err=%b req_ready=%b, required rdata=%h err=%b req_ready=0",
               tag, got_rd, got_err, req_ready[sel], exp_rd, exp_err);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid[sel] !== 1'b1 || rsp_rdata[sel] !== exp_rd || rsp_err[sel] !== exp_err ||
          req_ready[sel] !== 1'b0) begin
        n_mis++;
        $display("FAIL %s hold%0d: valid=%b rdata=%h err=%b req_ready=%b, required 1 %h %b 0",
                 tag, h, rsp_valid[sel], rsp_rdata[sel], rsp_err[sel], req_ready[sel], exp_rd, exp_err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (rsp_valid[sel] !== 1'b0 || req_ready[sel] !== 1'b1) begin
      n_mis++;
      $display("FAIL %s after_handshake: rsp_valid=%b req_ready=%b, required 0 1",
               tag, rsp_valid[sel], req_ready[sel]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b1; req_valid = '0;
    req_valid[0] = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h40; req_wdata = 32'h5A5A_5A5A; req_size = 3'd4;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid !== 3'b000) begin
        n_mis++;
        $display("FAIL reset_hold: rsp_valid=%b during reset, required 000", rsp_valid);
      end
    end
    req_valid = '0; rst = 1'b0;
    for (int s = 0; s < NI; s++) begin
      n_vec++;
      if (req_ready[s] !== 1'b1 || rsp_valid[s] !== 1'b0 || rsp_rdata[s] !== 32'h0 || rsp_err[s] !== 1'b0) begin
        n_mis++;
        $display("FAIL reset_state%0d: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
                 s, req_ready[s], rsp_valid[s], rsp_rdata[s], rsp_err[s]);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic e;
    do_txn(0, 1'b1, BASE, 32'hDEAD_BEEF, 3'd4, 0, "wr_word", rd, e);
    do_txn(0, 1'b0, BASE, 32'h0, 3'd4, 0, "rd_word", rd, e);
    n_vec++;
    if (rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
      n_mis++;
      $display("FAIL write_read: rdata=%h err=%b, required deadbeef 0", rd, e);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd; logic e;
    do_txn(0, 1'b1, BASE, 32'h1122_3344, 3'd4, 0, "preload", rd, e);
    do_txn(0, 1'b1, BASE + 32'd3, 32'h0000_00AA, 3'd1, 0, "wr_byte3", rd, e);
    do_txn(0, 1'b0, BASE, 32'h0, 3'd4, 0, "rd_byte3", rd, e);
    n_vec++;
    if (rd !== 32'hAA22_3344) begin
      n_mis++;
      $display("FAIL byte_write: rdata=%h, required aa223344", rd);
    end
  endtask

  task automatic test_halfword();
    logic [31:0] rd; logic e;
    do_txn(0, 1'b1, BASE, 32'h1122_3344, 3'd4, 0, "preload_h", rd, e);
    do_txn(0, 1'b1, BASE + 32'd2, 32'h0000_5566, 3'd2, 0, "wr_half2", rd, e);
    do_txn(0, 1'b0, BASE, 32'h0, 3'd1, 0, "rd_half2", rd, e);
    n_vec++;
    if (rd !== 32'h5566_3344) begin
      n_mis++;
      $display("FAIL half_lanes: rdata=%h, required 55663344", rd);
    end
    do_txn(0, 1'b1, BASE + 32'd3, 32'h0000_7788, 3'd2, 0, "wr_half3", rd, e);
    n_vec++;
    if (e !== 1'b1) begin
      n_mis++;
      $display("FAIL half_cross_err: err=%b, required 1", e);
    end
    do_txn(0, 1'b1, BASE, 32'hFFFF_FFFF, 3'd3, 0, "wr_size3", rd, e);
    n_vec++;
    if (e !== 1'b1) begin
      n_mis++;
      $display("FAIL size3_err: err=%b, required 1", e);
    end
    do_txn(0, 1'b0, BASE, 32'h0, 3'd4, 0, "rd_after_err", rd, e);
    n_vec++;
    if (rd !== 32'h5566_3344) begin
      n_mis++;
      $display("FAIL err_no_write: rdata=%h, required 55663344", rd);
    end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic e;
    do_txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 3'd4, 0, "rd_below", rd, e);
    n_vec++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      n_mis++;
      $display("FAIL range_below: rdata=%h err=%b, required 00000000 1", rd, e);
    end
    do_txn(0, 1'b0, 32'h8000_4000, 32'h0, 3'd4, 0, "rd_above", rd, e);
    n_vec++;
    if (rd !== 32'h0 || e !== 1'b1) begin
      n_mis++;
      $display("FAIL range_above: rdata=%h err=%b, required 00000000 1", rd, e);
    end
    do_txn(0, 1'b1, 32'h8000_3FFC, 32'h1357_9BDF, 3'd4, 0, "wr_last", rd, e);
    do_txn(0, 1'b0, 32'h8000_3FFC, 32'h0, 3'd4, 0, "rd_last", rd, e);
    n_vec++;
    if (rd !== 32'h1357_9BDF || e !== 1'b0) begin
      n_mis++;
      $display("FAIL range_last_word: rdata=%h err=%b, required 13579bdf 0", rd, e);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic e;
    do_txn(1, 1'b1, BASE + 32'h80, 32'h0F1E_2D3C, 3'd4, 5, "bp_write", rd, e);
    do_txn(1, 1'b0, BASE + 32'h80, 32'h0, 3'd4, 5, "bp_read", rd, e);
    n_vec++;
    if (rd !== 32'h0F1E_2D3C) begin
      n_mis++;
      $display("FAIL backpressure_read: rdata=%h, required 0f1e2d3c", rd);
    end
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd; logic e; logic [31:0] xr; bit xe;
    rsp_ready = 1'b1;
    req_valid[2] = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h100; req_wdata = 32'hCAFE_F00D; req_size = 3'd4;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    model_apply(2, 1'b1, BASE + 32'h100, 32'hCAFE_F00D, 3'd4, xr, xe);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if (req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_in_wait: req_ready=%b rsp_valid=%b, required 1 0", req_ready[2], rsp_valid[2]);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (rsp_valid[2] !== 1'b0) begin
        n_mis++;
        $display("FAIL dropped_rsp: rsp_valid=%b cycle %0d after reset, required 0", rsp_valid[2], i);
      end
    end
    do_txn(2, 1'b0, BASE + 32'h100, 32'h0, 3'd4, 0, "rd_after_rst", rd, e);
    n_vec++;
    if (rd !== 32'hCAFE_F00D) begin
      n_mis++;
      $display("FAIL write_survives_reset: rdata=%h, required cafef00d", rd);
    end
  endtask

  task automatic test_reset_ignore();
    logic [31:0] rd; logic e;
    do_txn(0, 1'b1, BASE + 32'h40, 32'h0BAD_F00D, 3'd4, 0, "wr_pre_rst", rd, e);
    rst = 1'b1;
    req_valid[0] = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h40; req_wdata = 32'hFFFF_FFFF; req_size = 3'd4;
    repeat (2) @(posedge clk);
    #1;
    req_valid[0] = 1'b0; rst = 1'b0;
    do_txn(0, 1'b0, BASE + 32'h40, 32'h0, 3'd4, 0, "rd_ignored", rd, e);
    n_vec++;
    if (rd !== 32'h0BAD_F00D) begin
      n_mis++;
      $display("FAIL reset_ignores_req: rdata=%h, required 0badf00d", rd);
    end
  endtask

  // Back-to-back random traffic in a 16-word window plus illegal sizes and out-of-range hits.
  task automatic test_random();
    logic [31:0] rd; logic e;
    logic [31:0] a;
    logic [2:0]  sizes [9];
    sizes = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0, 3'd5};
    for (int s = 0; s < NI; s++) begin
      for (int w = 0; w < 16; w++)
        do_txn(s, 1'b1, BASE + 32'h200 + 32'(4 * w), $urandom, 3'd4, 0, "rnd_fill", rd, e);
      for (int t = 0; t < 50; t++) begin
        if ($urandom_range(0, 7) == 0)
          a = ($urandom_range(0, 1) == 1) ? BASE - 32'($urandom_range(1, 64))
                                           : BASE + 32'h4000 + 32'($urandom_range(0, 64));
        else
          a = BASE + 32'h200 + 32'($urandom_range(0, 63));
        do_txn(s, 1'($urandom), a, $urandom, sizes[$urandom_range(0, 8)],
               int'($urandom_range(0, 2)), "rnd", rd, e);
      end
    end
  endtask

  initial begin
    req_valid = '0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = 3'd4;
    rsp_ready = 1'b1; rst = 1'b1;
    test_reset();
    test_write_read();
    test_byte_write();
    test_halfword();
    test_range();
    test_backpressure();
    test_reset_wait();
    test_reset_ignore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
